// File: rtl/dpram_fifo_ctrl.sv
// Purpose: synchronous FIFO controller around a 64x8 dual-port RAM (port A write, port B read).
// Latency: 3 cycles push-to-pop; a 2-entry output buffer hides the RAM read latency for 1 word/cycle.
// Backpressure: wr_ready drops when the RAM holds DEPTH words; rd_ready=0 stalls the buffer and read issue.
//
// Ports:
//   clock, reset_n (sync, active-low), flush (sync clear)
//   wr_valid/wr_data/wr_ready  : producer handshake
//   rd_valid/rd_data/rd_ready  : consumer handshake
//   level                      : words held (RAM + in-flight read + output buffer)
//   ram_*                      : connections to the dual-port RAM
module dpram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W+1:0] level,
    output logic [DATA_W-1:0] ram_data_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_data_b,
    output logic              ram_we_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    logic              fetch_pend;
    logic [DATA_W-1:0] ob_head;
    logic [DATA_W-1:0] ob_tail;
    logic [1:0]        ob_cnt;

    logic              push;
    logic              pop;
    logic              issue;
    logic [2:0]        credit_left;
    logic [1:0]        cap_idx;

    // Handshake outputs are forced low while reset is held so nothing
    // leaks out of uninitialised state during the first reset cycle.
    assign wr_ready = reset_n & (ram_cnt != DEPTH_C);
    assign push     = wr_valid & wr_ready;
    assign rd_valid = reset_n & (ob_cnt != 2'd0);
    assign pop      = rd_valid & rd_ready;
    assign rd_data  = ob_head;

    // Buffer slots already spoken for (held + in flight), less the one
    // freed by this cycle's pop; only issue when a slot remains.
    assign credit_left = 3'(ob_cnt) + 3'(fetch_pend) - 3'(pop);
    assign issue       = (ram_cnt != '0) & (credit_left < 3'd2);

    // Slot the returning RAM word lands in, after any same-cycle pop shift.
    assign cap_idx = ob_cnt - 2'(pop);

    assign ram_we_a   = push;
    assign ram_addr_a = wr_ptr;
    assign ram_data_a = wr_data;
    assign ram_addr_b = rd_ptr;
    assign ram_data_b = '0;
    assign ram_we_b   = 1'b0;

    assign level = reset_n ? ((ADDR_W + 2)'(ram_cnt) + (ADDR_W + 2)'(fetch_pend) + (ADDR_W + 2)'(ob_cnt))
                           : '0;

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            fetch_pend <= 1'b0;
            ob_head    <= '0;
            ob_tail    <= '0;
            ob_cnt     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            fetch_pend <= issue;
            ram_cnt    <= ram_cnt + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(issue);

            // Pop shifts the tail forward; a capture into slot 0 in the same
            // cycle is written afterwards and therefore takes precedence.
            if (pop) begin
                ob_head <= ob_tail;
            end
            if (fetch_pend) begin
                if (cap_idx == 2'd0) begin
                    ob_head <= ram_q_b;
                end else begin
                    ob_tail <= ram_q_b;
                end
            end
            ob_cnt <= ob_cnt - 2'(pop) + 2'(fetch_pend);
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
module tb_dpram_fifo_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready = 1'b0;
    logic [7:0] level;
    logic [7:0] ram_data_a;
    logic [5:0] ram_addr_a;
    logic       ram_we_a;
    logic [5:0] ram_addr_b;
    logic [7:0] ram_data_b;
    logic       ram_we_b;
    logic [7:0] ram_q_b;

    always #5 clock = ~clock;

    dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .level      (level),
        .ram_data_a (ram_data_a),
        .ram_addr_a (ram_addr_a),
        .ram_we_a   (ram_we_a),
        .ram_addr_b (ram_addr_b),
        .ram_data_b (ram_data_b),
        .ram_we_b   (ram_we_b),
        .ram_q_b    (ram_q_b)
    );

    // Behavioural 64x8 dual-port RAM with registered read.
    logic [7:0] mem [64];
    always @(posedge clock) begin
        ram_q_b <= mem[ram_addr_b];
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    end

    // Reference model: the FIFO contents as a plain queue plus a count of
    // words written since the last clear (gives the expected write address).
    logic [7:0] q [$];
    int         wcount;

    int vectors = 0;
    int miscompares = 0;

    // Values sampled inside the most recent cycle.
    logic       s_wr_ready, s_rd_valid, s_acc;
    logic [7:0] s_rd_data, s_level;
    logic [5:0] s_addr_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs,
    // then advance the reference model on the rising edge.
    task automatic tick(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
        logic acc, popped;
        @(negedge clock);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        #1;
        s_wr_ready = wr_ready;
        s_rd_valid = rd_valid;
        s_rd_data  = rd_data;
        s_level    = level;
        s_addr_b   = ram_addr_b;
        check("level", 32'(level), 32'(q.size()));
        check("we_b", 32'(ram_we_b), 32'd0);
        check("data_b", 32'(ram_data_b), 32'd0);
        if (q.size() < 64) check("wr_ready_space", 32'(wr_ready), 32'd1);
        if (q.size() == 0) check("rd_valid_empty", 32'(rd_valid), 32'd0);
        acc    = wv & wr_ready;
        popped = rd_valid & rr;
        check("we_a", 32'(ram_we_a), 32'(acc));
        if (acc) begin
            check("addr_a", 32'(ram_addr_a), 32'(wcount % 64));
            check("data_a", 32'(ram_data_a), 32'(wd));
        end
        if (popped && q.size() > 0) check("pop_data", 32'(rd_data), 32'(q[0]));
        s_acc = acc;
        @(posedge clock);
        if (fl) begin
            q.delete();
            wcount = 0;
        end else begin
            if (popped && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                q.push_back(wd);
                wcount++;
            end
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 300) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            guard++;
        end
        check("drain_done", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int acc_cnt;
        int got;

        // Reset held for two edges with a producer knocking.
        @(negedge clock);
        reset_n  = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        #1;
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_we_a", 32'(ram_we_a), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst2_we_a", 32'(ram_we_a), 32'd0);
        check("rst2_level", 32'(level), 32'd0);
        @(negedge clock);
        reset_n  = 1'b1;
        wr_valid = 1'b0;
        q.delete();
        wcount = 0;

        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("idle_wr_ready", 32'(s_wr_ready), 32'd1);
        check("idle_rd_valid", 32'(s_rd_valid), 32'd0);
        check("idle_level", 32'(s_level), 32'd0);

        // Single word: visible three cycles after the push cycle.
        tick(1'b1, 8'h33, 1'b1, 1'b0);
        check("sw_acc", 32'(s_acc), 32'd1);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("sw_level1", 32'(s_level), 32'd1);
        check("sw_addr_b", 32'(s_addr_b), 32'd0);
        check("sw_vld1", 32'(s_rd_valid), 32'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("sw_level2", 32'(s_level), 32'd1);
        check("sw_vld2", 32'(s_rd_valid), 32'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("sw_vld3", 32'(s_rd_valid), 32'd1);
        check("sw_dat3", 32'(s_rd_data), 32'h33);
        check("sw_level3", 32'(s_level), 32'd1);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("sw_level4", 32'(s_level), 32'd0);

        // Streaming 0x00..0x4F: no bubbles once the first word appears,
        // pointers wrap past 63.
        for (int k = 0; k < 84; k++) begin
            tick(k < 80, 8'(k), 1'b1, 1'b0);
            if (k < 80) check("st_acc", 32'(s_acc), 32'd1);
            if (k >= 3 && k < 83) begin
                check("st_vld", 32'(s_rd_valid), 32'd1);
                check("st_dat", 32'(s_rd_data), 32'(k - 3));
            end
        end
        drain();

        // Full: consumer stalled, 70 offered, 66 fit.
        acc_cnt = 0;
        for (int k = 0; k < 70; k++) begin
            tick(1'b1, 8'($urandom), 1'b0, 1'b0);
            if (s_acc) acc_cnt++;
        end
        check("full_acc", 32'(acc_cnt), 32'd66);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        check("full_level", 32'(s_level), 32'd66);
        check("full_wr_ready", 32'(s_wr_ready), 32'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("full_pop_wr_ready", 32'(s_wr_ready), 32'd0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        check("full_after_pop_wr_ready", 32'(s_wr_ready), 32'd1);
        check("full_after_pop_level", 32'(s_level), 32'd65);
        drain();

        // Random backpressure against the queue model.
        for (int k = 0; k < 500; k++) begin
            tick($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if (s_level > 8'd66) check("bp_level_max", 32'(s_level), 32'd66);
        end
        drain();

        // Flush mid-stream with a read in flight.
        for (int k = 0; k < 10; k++) tick(1'b1, 8'(8'hA0 + k), 1'b0, 1'b0);
        tick(1'b1, 8'hBB, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        check("fl_level_before", 32'(s_level), 32'd10);
        tick(1'b1, 8'h55, 1'b0, 1'b0);
        check("fl_level_after", 32'(s_level), 32'd0);
        check("fl_vld_after", 32'(s_rd_valid), 32'd0);
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            if (s_rd_valid) begin
                got = 1;
                check("fl_first_word", 32'(s_rd_data), 32'h55);
            end
        end
        check("fl_word_seen", 32'(got), 32'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
